// File: rtl/gpio_in_pkg.sv
// Shared constants and counter-width helper for the GPIO input conditioner.
// Board sizes mirror the MFP_N_SW / MFP_N_PB values of the MFP constants header.
package gpio_in_pkg;

   localparam int N_SW_DEFAULT = 16;
   localparam int N_PB_DEFAULT = 5;

   // 10 ms of stability at 50 MHz
   localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

   function automatic int cnt_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input lane: two-flop synchroniser followed by a stability counter that
// only accepts a new level after DEBOUNCE_CYCLES consecutive matching samples.
module debounce_bit
  import gpio_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;

  // Any sample that agrees with the accepted level restarts the count, so a
  // glitch shorter than the window never reaches clean.
  always_comb begin
    s1_d    = raw;
    s2_d    = s1_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (s2_q == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      clean_d = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean = clean_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Debounces Nexys4-DDR switches and buttons, generates button rise pulses and,
// when GPIO_INPUT_IRQ_EN is defined, sticky button events with a masked irq.
module gpio_input_conditioner
  import gpio_in_pkg::*;
#(
  parameter int N_SW            = N_SW_DEFAULT,
  parameter int N_PB            = N_PB_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_raw,
  input  logic [N_PB-1:0] pb_raw,
  output logic [N_SW-1:0] sw_clean,
  output logic [N_PB-1:0] pb_clean,
  output logic [N_PB-1:0] pb_rise,
  input  logic [N_PB-1:0] evt_clr,
  input  logic [N_PB-1:0] irq_mask,
  output logic [N_PB-1:0] pb_event,
  output logic            irq
);

  genvar gi;

  generate
    for (gi = 0; gi < N_SW; gi++) begin : g_sw
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk  (clk),
        .rst  (rst),
        .raw  (sw_raw[gi]),
        .clean(sw_clean[gi])
      );
    end
    for (gi = 0; gi < N_PB; gi++) begin : g_pb
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk  (clk),
        .rst  (rst),
        .raw  (pb_raw[gi]),
        .clean(pb_clean[gi])
      );
    end
  endgenerate

  logic [N_PB-1:0] pb_clean_dly_q, pb_clean_dly_d;
  logic [N_PB-1:0] pb_rise_q, pb_rise_d;

  always_comb begin
    pb_clean_dly_d = pb_clean;
    pb_rise_d      = pb_clean & ~pb_clean_dly_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pb_clean_dly_q <= '0;
      pb_rise_q      <= '0;
    end else begin
      pb_clean_dly_q <= pb_clean_dly_d;
      pb_rise_q      <= pb_rise_d;
    end
  end

  assign pb_rise = pb_rise_q;

`ifdef GPIO_INPUT_IRQ_EN
  logic [N_PB-1:0] pb_event_q, pb_event_d;
  logic            irq_q, irq_d;

  // A new rise beats a simultaneous clear so no press is ever lost.
  always_comb begin
    pb_event_d = (pb_event_q & ~evt_clr) | pb_rise_q;
    irq_d      = |(pb_event_q & irq_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pb_event_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      pb_event_q <= pb_event_d;
      irq_q      <= irq_d;
    end
  end

  assign pb_event = pb_event_q;
  assign irq      = irq_q;
`else
  logic unused_irq_inputs;

  assign unused_irq_inputs = ^{evt_clr, irq_mask};
  assign pb_event          = '0;
  assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner with DEBOUNCE_CYCLES=4; event and
// irq expectations follow whether GPIO_INPUT_IRQ_EN is defined.
module tb_gpio_input_conditioner;

  localparam int N_SW = 16;
  localparam int N_PB = 5;
  localparam int DEB  = 4;

`ifdef GPIO_INPUT_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N_SW-1:0] sw_raw;
  logic [N_PB-1:0] pb_raw;
  logic [N_SW-1:0] sw_clean;
  logic [N_PB-1:0] pb_clean;
  logic [N_PB-1:0] pb_rise;
  logic [N_PB-1:0] evt_clr;
  logic [N_PB-1:0] irq_mask;
  logic [N_PB-1:0] pb_event;
  logic            irq;

  int tests_run    = 0;
  int tests_failed = 0;

  gpio_input_conditioner #(
    .N_SW(N_SW), .N_PB(N_PB), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .pb_raw(pb_raw),
    .sw_clean(sw_clean), .pb_clean(pb_clean), .pb_rise(pb_rise),
    .evt_clr(evt_clr), .irq_mask(irq_mask), .pb_event(pb_event), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_PB-1:0] ev_exp(input logic [N_PB-1:0] v);
    return IRQ_BUILD ? v : '0;
  endfunction

  function automatic logic irq_exp(input logic v);
    return IRQ_BUILD ? v : 1'b0;
  endfunction

  initial begin
    rst = 1'b1; sw_raw = 16'h00A5; pb_raw = '0; evt_clr = '0; irq_mask = '0;
    repeat (3) tick();
    check_output("rst_sw_clean", 32'(sw_clean), 32'h0);
    check_output("rst_pb_clean", 32'(pb_clean), 32'h0);
    check_output("rst_pb_rise",  32'(pb_rise),  32'h0);
    check_output("rst_pb_event", 32'(pb_event), 32'h0);
    check_output("rst_irq",      32'(irq),      32'h0);

    // Reset release with switches already high: accepted at edge 6
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_output("release_sw_hold", 32'(sw_clean), 32'h0);
    end
    tick();
    check_output("release_sw_accept", 32'(sw_clean), 32'h00A5);
    check_output("release_pb_event",  32'(pb_event), 32'h0);
    check_output("release_irq",       32'(irq),      32'h0);

    // Bounce on button 0, then held high
    for (int k = 0; k < 4; k++) begin
      pb_raw[0] = (k % 2 == 0);
      tick();
      check_output("bounce_clean_low", 32'(pb_clean), 32'h0);
    end
    pb_raw[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_output("bounce_wait_clean", 32'(pb_clean), 32'h0);
      check_output("bounce_wait_rise",  32'(pb_rise),  32'h0);
    end
    tick();
    check_output("bounce_clean_up",   32'(pb_clean), 32'h01);
    check_output("bounce_rise_early", 32'(pb_rise),  32'h00);
    tick();
    check_output("bounce_rise_pulse", 32'(pb_rise), 32'h01);
    tick();
    check_output("bounce_rise_end",  32'(pb_rise),  32'h00);
    check_output("bounce_event_set", 32'(pb_event), 32'(ev_exp(5'b00001)));
    evt_clr = 5'b00001;
    tick();
    evt_clr = '0;
    check_output("bounce_event_clr", 32'(pb_event), 32'h0);

    // Release: falling edge gives no pulse
    pb_raw[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_output("fall_no_rise", 32'(pb_rise), 32'h0);
    end
    check_output("fall_clean_low", 32'(pb_clean), 32'h0);

    // Three-cycle glitch on switch 3
    sw_raw[3] = 1'b1;
    repeat (3) begin
      tick();
      check_output("glitch_sw_hold", 32'(sw_clean), 32'h00A5);
    end
    sw_raw[3] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_output("glitch_sw_after", 32'(sw_clean), 32'h00A5);
    end

    // Press button 2 with its interrupt enabled
    irq_mask  = 5'b00100;
    pb_raw[2] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_output("press2_irq_wait", 32'(irq), 32'h0);
    end
    check_output("press2_event_early", 32'(pb_event), 32'(ev_exp(5'b00100)));
    tick();
    check_output("press2_event", 32'(pb_event), 32'(ev_exp(5'b00100)));
    check_output("press2_irq",   32'(irq),      32'(irq_exp(1'b1)));
    evt_clr = 5'b00100;
    tick();
    evt_clr = '0;
    check_output("clr2_event",    32'(pb_event), 32'h0);
    check_output("clr2_irq_hold", 32'(irq),      32'(irq_exp(1'b1)));
    tick();
    check_output("clr2_irq_drop", 32'(irq), 32'h0);
    pb_raw[2] = 1'b0;
    repeat (8) tick();

    // Clear collides with the rise pulse on button 1
    pb_raw[1] = 1'b1;
    repeat (6) tick();
    check_output("press1_rise_early", 32'(pb_rise), 32'h0);
    tick();
    check_output("press1_rise", 32'(pb_rise), 32'h02);
    evt_clr = 5'b00010;
    tick();
    evt_clr = '0;
    check_output("collide_set_wins", 32'(pb_event), 32'(ev_exp(5'b00010)));
    check_output("collide_irq_masked", 32'(irq), 32'h0);
    evt_clr = 5'b00010;
    tick();
    evt_clr = '0;
    check_output("collide_later_clr", 32'(pb_event), 32'h0);
    pb_raw[1] = 1'b0;
    repeat (8) tick();

    // Events on buttons 0 and 4 with masking
    irq_mask = '0;
    pb_raw   = 5'b10001;
    repeat (9) tick();
    check_output("mask_events",  32'(pb_event), 32'(ev_exp(5'b10001)));
    check_output("mask_irq_off", 32'(irq),      32'h0);
    irq_mask = 5'b10000;
    tick();
    check_output("mask4_irq_on", 32'(irq), 32'(irq_exp(1'b1)));
    irq_mask = '0;
    tick();
    check_output("mask_irq_again_off", 32'(irq), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gpio_input_conditioner.md
# gpio_input_conditioner

Conditions the Nexys4-DDR slide switches and pushbuttons before they reach the CPU GPIO block's `IO_Switch`/`IO_PB` inputs. Each raw pad is synchronised with two flops and debounced by a per-input stability counter. The block also produces one-cycle debounced rising-edge pulses for the buttons. Optionally it latches sticky button events and raises a maskable interrupt request toward the CPU.

## Interface
Parameters:
- `N_SW`, 16, number of switches (matches `MFP_N_SW`)
- `N_PB`, 5, number of pushbuttons (matches `MFP_N_PB`)
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range 1..2^24-1

Ports:
- `clk` in 1: system clock; the only clock
- `rst` in 1: synchronous, active-high reset
- `sw_raw` in N_SW: asynchronous switch pads
- `pb_raw` in N_PB: asynchronous button pads, 1 = pressed
- `sw_clean` out N_SW: debounced switch levels, to GPIO `IO_Switch`
- `pb_clean` out N_PB: debounced button levels, to GPIO `IO_PB`
- `pb_rise` out N_PB: one-cycle pulse on each debounced 0→1 transition
- `evt_clr` in N_PB: write-1-to-clear strobes for `pb_event`
- `irq_mask` in N_PB: per-button interrupt enable, 1 = enabled
- `pb_event` out N_PB: sticky rising-edge flags
- `irq` out 1: registered interrupt request

## Operation
- Reset (`rst`=1 at a `clk` edge): sync flops, counters, `sw_clean`, `pb_clean`, `pb_rise`, `pb_event` and `irq` all become 0.
- Synchroniser: `s1 <= raw; s2 <= s1` for every input bit. Nothing downstream uses `raw` directly.
- Debounce counter, per bit, width `$clog2(DEBOUNCE_CYCLES+1)`:
  - if `s2 == clean`: `cnt <= 0`
  - else if `cnt == DEBOUNCE_CYCLES-1`: `clean <= s2`, `cnt <= 0`
  - else: `cnt <= cnt+1`
- A glitch that returns to the `clean` level before the count completes resets `cnt` and leaves `clean` unchanged. The counter never wraps.
- `pb_rise[i]` is 1 for exactly the cycle after `pb_clean[i]` goes 0→1. Falling transitions produce no pulse.
- `pb_event[i]`:
  - set when `pb_rise[i]` = 1
  - cleared when `evt_clr[i]` = 1
  - if set and clear occur in the same cycle, set wins
- `irq <= |(pb_event & irq_mask)`, registered. It deasserts the cycle after the last enabled flag clears or is masked.
- Switches have no edge or event logic.
- Reset asserted mid-count discards the partial count. Any input already high at reset release is re-accepted after the full debounce latency.

## Timing
- Raw change held stable → `clean` updates DEBOUNCE_CYCLES+2 edges later.
- `pb_clean` rise → `pb_rise` pulse +1 edge → `pb_event` set +1 edge → `irq` +1 edge.
- Total raw press → `irq`: DEBOUNCE_CYCLES+5 edges.
- `evt_clr` at edge k → `pb_event` 0 at k → `irq` 0 at k+1 (no other enabled flag pending).
- All outputs are flop-driven. There is no combinational path from input to output.

## Configuration
- Macro `GPIO_INPUT_IRQ_EN`.
- Defined: `pb_event` latch and `irq` behave as above.
- Undefined: `pb_event` and `irq` are tied to 0, `evt_clr`/`irq_mask` are ignored, and no event flops are synthesised.
- Debounce, `clean` and `pb_rise` are identical in both builds.

## Structure
- Shared package `gpio_in_pkg`:
  - `DEBOUNCE_CYCLES_DEFAULT`
  - counter width function / `CNT_W` localparam derivation
- `N_SW`/`N_PB` defaults come from `mfp_ahb_const.vh`.
- One sub-module, `debounce_bit` (sync pair + counter + clean flop, parameterised by `DEBOUNCE_CYCLES`). It is instantiated N_SW+N_PB times via generate.
- Edge detect, event latch and irq live in the top.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset release with `sw_raw`=16'h00A5: all outputs 0 through edge 5, then `sw_clean`=16'h00A5 at edge 6; `pb_event`=0, `irq`=0.
- Bounce: `pb_raw[0]` toggles 1,0,1,0 on successive cycles, then held 1: no `pb_clean` change until 6 edges after the final rise; then exactly one `pb_rise[0]` pulse.
- Glitch of 3 cycles on `sw_raw[3]`: `sw_clean[3]` never changes.
- Press `pb_raw[2]` with `irq_mask`=5'b00100: `pb_event`=5'b00100 and `irq`=1 at raw+9 edges. Pulse `evt_clr[2]` → `pb_event`=0 that edge, `irq`=0 next edge.
- `evt_clr[1]` asserted in the same cycle as `pb_rise[1]`: `pb_event[1]` remains 1.
- `irq_mask`=0 with `pb_event`=5'b10001: `irq`=0. Set `irq_mask[4]`=1 → `irq`=1 one edge later.
- Build without `GPIO_INPUT_IRQ_EN`: a button press still gives `pb_rise`, while `pb_event` and `irq` stay 0.
